split_bus_arbiter: RTL and testbench

// - Arbiter/sequencer for the 2-master / 3-slave system bus. Owns bus_grant/slave_sel that steer the bus mux.
// - Adds round-robin fairness, split-transaction parking/resume and a transfer watchdog.
// - Sits between master request lines and the bus mux select inputs.

---
 rtl/split_bus_arbiter_pkg.sv | 29 ++
 rtl/split_bus_arbiter_if.sv | 33 +++
 rtl/split_bus_arbiter_watchdog.sv | 29 ++
 rtl/split_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_split_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/split_bus_arbiter_pkg.sv
// Shared encodings and state type for the 2-master / 3-slave split-bus arbiter.
package split_bus_arbiter_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  localparam logic [1:0] SL_NONE  = 2'b00;
  localparam logic [1:0] SL_S1    = 2'b01;
  localparam logic [1:0] SL_S2    = 2'b10;
  localparam logic [1:0] SL_S3    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Split request level of the slave addressed by sel; SL_NONE never splits.
  function automatic logic slave_split(input logic [1:0] sel, input logic [2:0] split_en);
    case (sel)
      SL_S1:   return split_en[0];
      SL_S2:   return split_en[1];
      SL_S3:   return split_en[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/split_bus_arbiter_if.sv
// Request/grant/split bundle between the masters, slaves and the arbiter.
interface split_bus_arbiter_if;
  logic       m1_request;
  logic       m2_request;
  logic [1:0] m1_slave_sel;
  logic [1:0] m2_slave_sel;
  logic       trans_done;
  logic       s1_slave_split_en;
  logic       s2_slave_split_en;
  logic       s3_slave_split_en;
  logic       m1_grant;
  logic       m2_grant;
  logic [1:0] bus_grant;
  logic [1:0] slave_sel;
  logic       arbiter_busy;
  logic       bus_busy;
  logic       split_pending;
  logic       timeout_err;

  modport master (
    output m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
           s1_slave_split_en, s2_slave_split_en, s3_slave_split_en,
    input  m1_grant, m2_grant, bus_grant, slave_sel, arbiter_busy, bus_busy,
           split_pending, timeout_err
  );

  modport slave (
    input  m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
           s1_slave_split_en, s2_slave_split_en, s3_slave_split_en,
    output m1_grant, m2_grant, bus_grant, slave_sel, arbiter_busy, bus_busy,
           split_pending, timeout_err
  );
endinterface

// File: rtl/split_bus_arbiter_watchdog.sv
// Data-phase watchdog: down-counter reloaded while cleared, expire on terminal count.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMR_W          = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= LOAD_VAL;
    end else if (i_clear) begin
      r_count <= LOAD_VAL;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - TMR_W'(1);
    end
  end

  assign o_expire = i_enable && (r_count == '0);

endmodule

// File: rtl/split_bus_arbiter.sv
// Bus arbiter/sequencer: round-robin or fixed priority, split parking/resume and
// a data-phase watchdog. Every output is a register.
module split_bus_arbiter
  import split_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMR_W          = 9,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input logic           sys_clk,
  input logic           sys_rst,
  split_bus_arbiter_if.slave bus
);

  arb_state_t r_state;
  logic       r_rr_last_m2;
  logic       r_owner_m2;
  logic       r_split_pending;
  logic       r_split_m2;
  logic [1:0] r_split_slave;
  logic       r_m1_grant;
  logic       r_m2_grant;
  logic [1:0] r_bus_grant;
  logic [1:0] r_slave_sel;
  logic       r_arbiter_busy;
  logic       r_bus_busy;
  logic       r_timeout_err;

  logic [2:0] w_split_en;
  logic       w_split_released;
  logic       w_m1_elig;
  logic       w_m2_elig;
  logic       w_resume;
  logic       w_pick_valid;
  logic       w_pick_m2;
  logic [1:0] w_pick_sel;
  logic       w_park;
  logic       w_expire;

  assign w_split_en = {bus.s3_slave_split_en, bus.s2_slave_split_en, bus.s1_slave_split_en};
  assign w_split_released = r_split_pending && !slave_split(r_split_slave, w_split_en);

  // A parked master, and anyone aiming at the parked slave, waits for the resume.
  assign w_m1_elig = bus.m1_request && (bus.m1_slave_sel != SL_NONE) &&
                     !(r_split_pending && (!r_split_m2 || (bus.m1_slave_sel == r_split_slave)));
  assign w_m2_elig = bus.m2_request && (bus.m2_slave_sel != SL_NONE) &&
                     !(r_split_pending && (r_split_m2 || (bus.m2_slave_sel == r_split_slave)));
  assign w_resume  = w_split_released &&
                     (r_split_m2 ? (bus.m2_request && (bus.m2_slave_sel != SL_NONE))
                                 : (bus.m1_request && (bus.m1_slave_sel != SL_NONE)));

  always_comb begin
    w_pick_valid = w_resume || w_m1_elig || w_m2_elig;
    w_pick_m2    = 1'b0;
    if (w_resume) begin
      w_pick_m2 = r_split_m2;
    end else if (w_m1_elig && w_m2_elig) begin
      w_pick_m2 = !FIXED_PRIO && !r_rr_last_m2;
    end else begin
      w_pick_m2 = w_m2_elig;
    end
  end

  assign w_pick_sel = w_pick_m2 ? bus.m2_slave_sel : bus.m1_slave_sel;
  assign w_park     = slave_split(r_slave_sel, w_split_en) && !r_split_pending;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_watchdog (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_clear (r_state != DATA),
    .i_enable(r_state == DATA),
    .o_expire(w_expire)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state         <= IDLE;
      r_rr_last_m2    <= 1'b1;
      r_owner_m2      <= 1'b0;
      r_split_pending <= 1'b0;
      r_split_m2      <= 1'b0;
      r_split_slave   <= SL_NONE;
      r_m1_grant      <= 1'b0;
      r_m2_grant      <= 1'b0;
      r_bus_grant     <= GNT_NONE;
      r_slave_sel     <= SL_NONE;
      r_arbiter_busy  <= 1'b0;
      r_bus_busy      <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state        <= ADDR;
            r_owner_m2     <= w_pick_m2;
            r_m1_grant     <= !w_pick_m2;
            r_m2_grant     <= w_pick_m2;
            r_bus_grant    <= w_pick_m2 ? GNT_M2 : GNT_M1;
            r_slave_sel    <= w_pick_sel;
            r_arbiter_busy <= 1'b1;
            if (w_resume) r_split_pending <= 1'b0;
          end
        end
        ADDR: begin
          r_state        <= DATA;
          r_arbiter_busy <= 1'b0;
          r_bus_busy     <= 1'b1;
        end
        DATA: begin
          if (bus.trans_done || w_park || w_expire) begin
            r_state     <= IDLE;
            r_m1_grant  <= 1'b0;
            r_m2_grant  <= 1'b0;
            r_bus_grant <= GNT_NONE;
            r_slave_sel <= SL_NONE;
            r_bus_busy  <= 1'b0;
            // Completion beats a split request, which beats the watchdog.
            if (bus.trans_done) begin
              r_rr_last_m2 <= r_owner_m2;
            end else if (w_park) begin
              r_split_pending <= 1'b1;
              r_split_m2      <= r_owner_m2;
              r_split_slave   <= r_slave_sel;
            end else begin
              r_timeout_err <= 1'b1;
              r_rr_last_m2  <= r_owner_m2;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m1_grant      = r_m1_grant;
  assign bus.m2_grant      = r_m2_grant;
  assign bus.bus_grant     = r_bus_grant;
  assign bus.slave_sel     = r_slave_sel;
  assign bus.arbiter_busy  = r_arbiter_busy;
  assign bus.bus_busy      = r_bus_busy;
  assign bus.split_pending = r_split_pending;
  assign bus.timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter: vector table, directed split/timeout/reset
// sequences and random traffic against a transaction-level reference model.
module tb_split_bus_arbiter;

  localparam int TMO = 8;

  logic sys_clk;
  logic sys_rst;
  int   n_vec;
  int   n_err;

  split_bus_arbiter_if bus ();

  split_bus_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .TMR_W         (4),
    .FIXED_PRIO    (1'b0)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required to finish");
    $fatal(1);
  end

  // Reference model: who owns the bus, which phase, who is parked where.
  int mo_owner;
  int mo_oslave;
  bit mo_addr;
  int mo_age;
  int mo_parked;
  int mo_pslave;
  int mo_last;
  bit mo_to;

  task automatic model_reset();
    mo_owner = 0; mo_oslave = 0; mo_addr = 1'b0; mo_age = -1;
    mo_parked = 0; mo_pslave = 0; mo_last = 2; mo_to = 1'b0;
  endtask

  task automatic model_step();
    int req[3];
    int sel[3];
    bit spl[4];
    int cand[$];
    int pick;
    req[0] = 0; sel[0] = 0;
    req[1] = int'(bus.m1_request); sel[1] = int'(bus.m1_slave_sel);
    req[2] = int'(bus.m2_request); sel[2] = int'(bus.m2_slave_sel);
    spl[0] = 1'b0;
    spl[1] = bus.s1_slave_split_en;
    spl[2] = bus.s2_slave_split_en;
    spl[3] = bus.s3_slave_split_en;
    mo_to = 1'b0;
    if (mo_addr) begin
      mo_addr = 1'b0;
      mo_age  = 0;
    end else if (mo_age >= 0) begin
      if (bus.trans_done) begin
        mo_last = mo_owner; mo_owner = 0; mo_age = -1;
      end else if (spl[mo_oslave] && mo_parked == 0) begin
        mo_parked = mo_owner; mo_pslave = mo_oslave; mo_owner = 0; mo_age = -1;
      end else if (mo_age == TMO - 1) begin
        mo_to = 1'b1; mo_last = mo_owner; mo_owner = 0; mo_age = -1;
      end else begin
        mo_age++;
      end
    end else begin
      pick = 0;
      if (mo_parked != 0 && !spl[mo_pslave] && req[mo_parked] != 0 && sel[mo_parked] != 0) begin
        pick = mo_parked;
        mo_parked = 0;
      end else begin
        for (int m = 1; m <= 2; m++)
          if (req[m] != 0 && sel[m] != 0 && mo_parked != m &&
              !(mo_parked != 0 && sel[m] == mo_pslave))
            cand.push_back(m);
        if (cand.size() == 1) pick = cand[0];
        else if (cand.size() == 2) pick = 3 - mo_last;
      end
      if (pick != 0) begin
        mo_owner = pick; mo_oslave = sel[pick]; mo_addr = 1'b1;
      end
    end
  endtask

  function automatic logic [9:0] model_vec();
    return {(mo_owner == 1), (mo_owner == 2), 2'(mo_owner),
            ((mo_owner != 0) ? 2'(mo_oslave) : 2'b00),
            mo_addr, (mo_age >= 0), (mo_parked != 0), mo_to};
  endfunction

  function automatic logic [9:0] got_vec();
    return {bus.m1_grant, bus.m2_grant, bus.bus_grant, bus.slave_sel,
            bus.arbiter_busy, bus.bus_busy, bus.split_pending, bus.timeout_err};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input bit m1r, input bit m2r, input logic [1:0] m1s,
                       input logic [1:0] m2s, input bit done, input logic [2:0] spl);
    bus.m1_request = m1r; bus.m2_request = m2r;
    bus.m1_slave_sel = m1s; bus.m2_slave_sel = m2s;
    bus.trans_done = done;
    bus.s1_slave_split_en = spl[0];
    bus.s2_slave_split_en = spl[1];
    bus.s3_slave_split_en = spl[2];
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
    check("model", got_vec(), model_vec());
  endtask

  task automatic apply_reset();
    #2;
    sys_rst = 1'b1;
    #1;
    check("rst_async", got_vec(), 10'b0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
  endtask

  // Output bits: {m1_grant, m2_grant, bus_grant, slave_sel, arbiter_busy, bus_busy, split_pending, timeout_err}
  typedef struct {
    bit         m1r;
    bit         m2r;
    logic [1:0] m1s;
    logic [1:0] m2s;
    bit         done;
    logic [2:0] spl;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[17];

  initial begin
    n_vec = 0;
    n_err = 0;
    sys_rst = 1'b1;
    drive(0, 0, 2'b00, 2'b00, 0, 3'b000);
    model_reset();

    tbl[0]  = '{1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 3'b000, 10'b1001011000};
    tbl[1]  = '{1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 3'b000, 10'b1001010100};
    tbl[2]  = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 3'b000, 10'b0000000000};
    tbl[3]  = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 10'b0110111000};
    tbl[4]  = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 10'b0110110100};
    tbl[5]  = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 10'b0110110100};
    tbl[6]  = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b1, 3'b000, 10'b0000000000};
    tbl[7]  = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 10'b1001101000};
    tbl[8]  = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 10'b1001100100};
    tbl[9]  = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b1, 3'b000, 10'b0000000000};
    tbl[10] = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 10'b0110111000};
    tbl[11] = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 10'b0110110100};
    tbl[12] = '{1'b0, 1'b0, 2'b10, 2'b11, 1'b1, 3'b000, 10'b0000000000};
    tbl[13] = '{1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 3'b000, 10'b0000000000};
    tbl[14] = '{1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 3'b000, 10'b0110011000};
    tbl[15] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 3'b000, 10'b0110010100};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 3'b000, 10'b0000000000};

    apply_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].m1r, tbl[i].m2r, tbl[i].m1s, tbl[i].m2s, tbl[i].done, tbl[i].spl);
      cycle();
      check($sformatf("tbl%0d", i), got_vec(), tbl[i].exp);
    end

    // Split park on s2, blocked competitor, resume ahead of the other master.
    apply_reset();
    drive(1, 0, 2'b10, 2'b00, 0, 3'b000);
    cycle();
    cycle();
    drive(1, 0, 2'b10, 2'b00, 0, 3'b010);
    cycle();
    check("split_m1_drop", 10'(bus.m1_grant), 10'd0);
    check("split_pending_set", 10'(bus.split_pending), 10'd1);
    drive(1, 1, 2'b10, 2'b10, 0, 3'b010);
    cycle();
    cycle();
    check("split_m2_blocked", 10'(bus.m2_grant), 10'd0);
    drive(1, 1, 2'b10, 2'b11, 0, 3'b010);
    cycle();
    check("split_m2_other_slave", {bus.m2_grant, bus.bus_grant, bus.slave_sel}, 10'b1_10_11);
    cycle();
    drive(1, 1, 2'b10, 2'b11, 0, 3'b000);
    cycle();
    drive(1, 1, 2'b10, 2'b11, 1, 3'b000);
    cycle();
    drive(1, 1, 2'b10, 2'b11, 0, 3'b000);
    cycle();
    check("resume_m1_first", {bus.m1_grant, bus.m2_grant, bus.slave_sel}, 10'b1_0_10);
    check("resume_pending_clr", 10'(bus.split_pending), 10'd0);
    cycle();
    drive(0, 0, 2'b10, 2'b11, 1, 3'b000);
    cycle();

    // Watchdog: no trans_done after DATA entry.
    apply_reset();
    drive(1, 0, 2'b01, 2'b00, 0, 3'b000);
    cycle();
    drive(0, 0, 2'b01, 2'b00, 0, 3'b000);
    cycle();
    for (int i = 1; i <= TMO; i++) begin
      cycle();
      check($sformatf("timeout_err_%0d", i), 10'(bus.timeout_err), 10'(i == TMO));
    end
    check("timeout_grants", {bus.m1_grant, bus.m2_grant, bus.bus_grant}, 10'd0);
    cycle();
    check("timeout_after", {bus.timeout_err, bus.m1_grant, bus.m2_grant, bus.bus_busy}, 10'd0);

    // Reset mid-DATA, then normal 1-cycle grant latency.
    drive(1, 0, 2'b01, 2'b00, 0, 3'b000);
    cycle();
    cycle();
    check("pre_rst_busy", 10'(bus.bus_busy), 10'd1);
    apply_reset();
    drive(0, 1, 2'b00, 2'b11, 0, 3'b000);
    cycle();
    check("post_rst_grant", {bus.m2_grant, bus.arbiter_busy, bus.bus_grant}, 10'b1_1_10);
    drive(0, 0, 2'b00, 2'b11, 1, 3'b000);
    cycle();

    // Random traffic against the model, with periodic async resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(4) == 0) bus.m1_request = ~bus.m1_request;
      if ($urandom_range(4) == 0) bus.m2_request = ~bus.m2_request;
      if ($urandom_range(3) == 0) bus.m1_slave_sel = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) bus.m2_slave_sel = 2'($urandom_range(3));
      bus.trans_done = ($urandom_range(5) == 0);
      if ($urandom_range(9) == 0) bus.s1_slave_split_en = ~bus.s1_slave_split_en;
      if ($urandom_range(9) == 0) bus.s2_slave_split_en = ~bus.s2_slave_split_en;
      if ($urandom_range(9) == 0) bus.s3_slave_split_en = ~bus.s3_slave_split_en;
      cycle();
      if (n % 200 == 199) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
